// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - shared state encoding and defaults for the UART transmit scheduler
package uart_sched_pkg;

  localparam int NREQ_DEFAULT = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK  = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts at pri and wraps
module rr_pick
  import uart_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pri,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx
);

  int j;

  // Walk the ring from the far end so the candidate closest to pri wins last.
  always_comb begin
    pick = '0;
    idx  = '0;
    j    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(pri) + k) % NREQ;
      if (req[j]) begin
        pick    = '0;
        pick[j] = 1'b1;
        idx     = PW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART transmitter between byte producers
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ_VALID,
  input  logic [8*NREQ-1:0] REQ_DATA,
  input  logic [NREQ-1:0]   REQ_LAST,
  output logic [NREQ-1:0]   REQ_READY,
  output logic [7:0]        TX_DATA,
  output logic              TX_WE,
  input  logic              TX_READY,
  output logic [NREQ-1:0]   GRANT,
  output logic              BUSY
);

  localparam int PW = $clog2(NREQ);

  state_t          state, state_nx;
  logic [PW-1:0]   pri, pri_nx;
  logic [PW-1:0]   owner, owner_nx;
  logic            last_q, last_nx;
  logic            accept;
  logic [7:0]      byte_sel;
  logic [NREQ-1:0] owner_oh;
  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req  (REQ_VALID),
    .pri  (pri),
    .pick (pick_oh),
    .idx  (pick_idx)
  );

  always_comb begin
    state_nx  = state;
    pri_nx    = pri;
    owner_nx  = owner;
    last_nx   = last_q;
    accept    = 1'b0;
    REQ_READY = '0;
    case (state)
      S_IDLE: begin
        if (TX_READY && |REQ_VALID) begin
          accept    = 1'b1;
          owner_nx  = pick_idx;
          REQ_READY = pick_oh;
          state_nx  = S_ISSUE;
        end
      end
      S_LOCK: begin
        if (TX_READY && REQ_VALID[owner]) begin
          accept           = 1'b1;
          REQ_READY[owner] = 1'b1;
          state_nx         = S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        // The transmitter drops READY after the strobe, so the first high READY here means done.
        if (TX_READY) begin
          if (last_q) begin
            state_nx = S_IDLE;
            pri_nx   = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
          end else begin
            state_nx = S_LOCK;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
    byte_sel = REQ_DATA[8*owner_nx +: 8];
    if (accept) begin
      last_nx = REQ_LAST[owner_nx];
    end
    owner_oh           = '0;
    owner_oh[owner_nx] = 1'b1;
    if (RST) begin
      REQ_READY = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      pri     <= '0;
      owner   <= '0;
      last_q  <= 1'b0;
      TX_WE   <= 1'b0;
      TX_DATA <= 8'h00;
      GRANT   <= '0;
      BUSY    <= 1'b0;
    end else begin
      state   <= state_nx;
      pri     <= pri_nx;
      owner   <= owner_nx;
      last_q  <= last_nx;
      TX_WE   <= accept;
      TX_DATA <= accept ? byte_sel : 8'h00;
      GRANT   <= (state_nx == S_IDLE) ? '0 : owner_oh;
      BUSY    <= (state_nx != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized self-checking bench for uart_tx_sched against a transaction model
module tb_uart_tx_sched;

  localparam int N = 3;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         gap;
  } ent_t;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   REQ_VALID;
  logic [8*N-1:0] REQ_DATA;
  logic [N-1:0]   REQ_LAST;
  logic [N-1:0]   REQ_READY;
  logic [7:0]     TX_DATA;
  logic           TX_WE;
  logic           TX_READY;
  logic [N-1:0]   GRANT;
  logic           BUSY;

  always #5 CLK = ~CLK;

  uart_tx_sched #(.NREQ(N)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_LAST  (REQ_LAST),
    .REQ_READY (REQ_READY),
    .TX_DATA   (TX_DATA),
    .TX_WE     (TX_WE),
    .TX_READY  (TX_READY),
    .GRANT     (GRANT),
    .BUSY      (BUSY)
  );

  int checks   = 0;
  int failures = 0;

  // producers
  ent_t pq[N][$];
  bit   loaded[N];
  int   gapc[N];

  // reference model: who owns the transmitter and where the current byte is
  int         cyc;
  int         m_owner;
  int         m_pri;
  int         m_acc_cyc;
  bit         m_inflight;
  bit         m_last;
  logic [7:0] m_byte;

  // transmitter model
  int u_cnt;
  bit u_we_prev;
  bit u_hold_rst;
  int frame;

  bit rand_mode;
  bit rst_on_issue;
  bit rst_now;

  logic [7:0] exp_line[$];
  logic [7:0] act_line[$];
  logic [7:0] want[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit work_left();
    bit w;
    w = m_inflight || (m_owner >= 0) || (u_cnt > 0);
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) w = 1'b1;
    return w;
  endfunction

  task automatic step();
    bit             exp_we;
    int             pick;
    logic [N-1:0]   exp_rdy;
    logic [N-1:0]   vld;
    logic [8*N-1:0] dat;
    logic [N-1:0]   lst;
    bit             vi;
    int             j;

    exp_we = m_inflight && (cyc == m_acc_cyc + 1);
    check_eq("tx_we", TX_WE, exp_we);
    check_eq("tx_data", TX_DATA, exp_we ? m_byte : 8'h00);
    check_eq("busy", BUSY, m_owner >= 0);
    check_eq("grant", GRANT, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    if (TX_WE) act_line.push_back(TX_DATA);

    if (u_cnt > 0) u_cnt--;
    if (u_we_prev && !u_hold_rst) u_cnt = frame;
    u_we_prev = TX_WE;
    TX_READY  = (u_cnt == 0);

    RST = rst_now || (rst_on_issue && exp_we) || (rand_mode && $urandom_range(0, 299) == 0);
    if (rst_on_issue && exp_we) rst_on_issue = 1'b0;
    rst_now = 1'b0;

    for (int i = 0; i < N; i++) begin
      vi = 1'b0;
      if (pq[i].size() > 0) begin
        if (!loaded[i]) begin
          gapc[i]   = pq[i][0].gap;
          loaded[i] = 1'b1;
        end
        if (gapc[i] > 0) gapc[i]--;
        else vi = !(rand_mode && $urandom_range(0, 7) == 0);
      end
      vld[i] = vi;
      if (vi) begin
        dat[8*i +: 8] = pq[i][0].data;
        lst[i]        = pq[i][0].last;
      end else begin
        dat[8*i +: 8] = 8'($urandom);
        lst[i]        = 1'($urandom);
      end
    end
    REQ_VALID = vld;
    REQ_DATA  = dat;
    REQ_LAST  = lst;
    #1;

    pick    = -1;
    exp_rdy = '0;
    if (!RST && !m_inflight && TX_READY) begin
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          j = (m_pri + k) % N;
          if (pick < 0 && vld[j]) pick = j;
        end
      end else if (vld[m_owner]) begin
        pick = m_owner;
      end
    end
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    check_eq("req_ready", REQ_READY, exp_rdy);

    if (RST) begin
      m_owner    = -1;
      m_pri      = 0;
      m_inflight = 1'b0;
    end else if (pick >= 0) begin
      m_inflight = 1'b1;
      m_acc_cyc  = cyc;
      m_owner    = pick;
      m_byte     = dat[8*pick +: 8];
      m_last     = lst[pick];
      exp_line.push_back(m_byte);
    end else if (m_inflight && cyc >= m_acc_cyc + 2 && TX_READY) begin
      m_inflight = 1'b0;
      if (m_last) begin
        m_pri   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end

    for (int i = 0; i < N; i++) begin
      if (REQ_READY[i] && pq[i].size() > 0) begin
        void'(pq[i].pop_front());
        loaded[i] = 1'b0;
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  task automatic run_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (work_left() && n < budget) begin
      step();
      n++;
    end
    check_eq({tag, "_done_in_budget"}, n < budget, 1'b1);
    repeat (2) step();
  endtask

  task automatic check_line(input string tag, input bit use_want);
    check_eq({tag, "_count"}, act_line.size(), exp_line.size());
    for (int i = 0; i < act_line.size() && i < exp_line.size(); i++)
      check_eq({tag, "_byte"}, act_line[i], exp_line[i]);
    if (use_want) begin
      check_eq({tag, "_order_count"}, act_line.size(), want.size());
      for (int i = 0; i < act_line.size() && i < want.size(); i++)
        check_eq({tag, "_order"}, act_line[i], want[i]);
    end
    act_line.delete();
    exp_line.delete();
    want.delete();
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l, input int g);
    ent_t e;
    e.data = d;
    e.last = l;
    e.gap  = g;
    pq[r].push_back(e);
  endtask

  task automatic reset_pulse();
    rst_now = 1'b1;
    step();
  endtask

  initial begin
    cyc        = 0;
    m_owner    = -1;
    m_pri      = 0;
    m_acc_cyc  = -10;
    m_inflight = 1'b0;
    m_last     = 1'b0;
    m_byte     = 8'h00;
    u_cnt      = 0;
    u_we_prev  = 1'b0;
    u_hold_rst = 1'b0;
    frame      = 6;
    rand_mode  = 1'b0;
    rst_on_issue = 1'b0;
    rst_now    = 1'b0;
    for (int i = 0; i < N; i++) begin
      loaded[i] = 1'b0;
      gapc[i]   = 0;
    end

    RST       = 1'b1;
    TX_READY  = 1'b1;
    REQ_VALID = '1;
    REQ_DATA  = 24'hA5A5A5;
    REQ_LAST  = '1;
    @(negedge CLK);
    check_eq("rst_tx_we", TX_WE, 1'b0);
    check_eq("rst_tx_data", TX_DATA, 8'h00);
    check_eq("rst_grant", GRANT, 3'b000);
    check_eq("rst_busy", BUSY, 1'b0);
    check_eq("rst_req_ready", REQ_READY, 3'b000);

    // single byte
    push(0, 8'h41, 1'b1, 0);
    run_idle("single", 200);
    want.push_back(8'h41);
    check_line("single", 1'b1);

    // simultaneous requests, req0 comes back only after 1 and 2
    reset_pulse();
    push(0, 8'hA0, 1'b1, 0);
    push(0, 8'hA3, 1'b1, 0);
    push(1, 8'hA1, 1'b1, 0);
    push(2, 8'hA2, 1'b1, 0);
    run_idle("simul", 300);
    want = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    check_line("simul", 1'b1);

    // message lock
    reset_pulse();
    push(1, 8'h4F, 1'b0, 0);
    push(1, 8'h4B, 1'b0, 0);
    push(1, 8'h0A, 1'b1, 0);
    push(0, 8'h55, 1'b1, 1);
    run_idle("lock", 300);
    want = '{8'h4F, 8'h4B, 8'h0A, 8'h55};
    check_line("lock", 1'b1);

    // owner stall
    reset_pulse();
    push(2, 8'h11, 1'b0, 0);
    push(2, 8'h12, 1'b1, 50);
    push(0, 8'h30, 1'b1, 2);
    run_idle("stall", 400);
    want = '{8'h11, 8'h12, 8'h30};
    check_line("stall", 1'b1);

    // reset in the issue cycle of req1, then pointer must be back at 0
    reset_pulse();
    push(0, 8'h20, 1'b1, 0);
    run_idle("pre_rst", 200);
    push(1, 8'h21, 1'b1, 0);
    rst_on_issue = 1'b1;
    run_idle("mid_rst", 200);
    push(0, 8'h23, 1'b1, 0);
    push(2, 8'h24, 1'b1, 0);
    run_idle("post_rst", 300);
    want = '{8'h20, 8'h21, 8'h23, 8'h24};
    check_line("reset", 1'b1);

    // back-to-back stream with a 4x10 bit-time frame
    reset_pulse();
    frame = 40;
    for (int i = 0; i < 16; i++) begin
      push(0, 8'(i * 7 + 3), (i == 15), 0);
      want.push_back(8'(i * 7 + 3));
    end
    run_idle("stream", 2000);
    check_line("stream", 1'b1);

    // randomized traffic
    rand_mode = 1'b1;
    for (int round = 0; round < 8; round++) begin
      int nmsg;
      int len;
      frame      = $urandom_range(1, 5);
      u_hold_rst = ($urandom_range(0, 3) == 0);
      for (int r = 0; r < N; r++) begin
        nmsg = $urandom_range(1, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            push(r, 8'($urandom), (b == len - 1), $urandom_range(0, 3));
        end
      end
      run_idle("random", 3000);
      check_line("random", 1'b0);
    end
    rand_mode  = 1'b0;
    u_hold_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
